ring_counter_param: RTL and testbench

Parametrised successor to the team's fixed 4-bit ring counter. Generates a one-hot ring sequence or a Johnson (twisted-ring) sequence of configurable width. Adds enable, bidirectional stepping, synchronous position load, a position index and a wrap pulse. Used as a phase/slot sequencer for multiplexed datapaths and LED/scan drivers.

---
 rtl/ring_counter_param_if.sv | 34 +++
 rtl/ring_counter_param.sv | 125 ++++++++++++
 tb/tb_ring_counter_param.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ring_counter_param_if.sv
// ----------------------------------------------------------------------------
// ring_counter_param_if
// Bundles the control inputs and status outputs of ring_counter_param.
//   master : drives en, dir, load, load_pos; observes dout, pos, wrap, err
//   slave  : the counter itself
// Parameters mirror the counter (WIDTH, JOHNSON) so that the position
// field width PW is derived identically on both sides.
// ----------------------------------------------------------------------------
interface ring_counter_param_if #(
  parameter int WIDTH   = 4,
  parameter int JOHNSON = 0
);
  localparam int PERIOD = (JOHNSON != 0) ? 2 * WIDTH : WIDTH;
  localparam int PW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  logic             en;
  logic             dir;
  logic             load;
  logic [PW-1:0]    load_pos;
  logic [WIDTH-1:0] dout;
  logic [PW-1:0]    pos;
  logic             wrap;
  logic             err;

  modport master (
    output en, dir, load, load_pos,
    input  dout, pos, wrap, err
  );

  modport slave (
    input  en, dir, load, load_pos,
    output dout, pos, wrap, err
  );
endinterface

// File: rtl/ring_counter_param.sv
// ----------------------------------------------------------------------------
// ring_counter_param
// Parametrised one-hot ring / Johnson (twisted-ring) sequencer with enable,
// bidirectional stepping, synchronous position load, a position index and a
// registered wrap pulse. Intended as a phase/slot sequencer.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high reset
//   bus    : ring_counter_param_if.slave
//            en, dir (0 up / 1 down), load, load_pos  -> inputs
//            dout, pos, wrap, err                     -> registered outputs
//
// Parameters:
//   WIDTH   : output bits, 2..32
//   JOHNSON : 0 = one-hot ring (period WIDTH), 1 = Johnson (period 2*WIDTH)
//
// Optional feature macro: RING_COUNTER_PARAM_SELF_CORRECT_EN
//   When defined, dout is checked against the pattern implied by pos every
//   cycle; a mismatch restores dout from pos, pulses err and ignores en/load
//   for that cycle. When undefined, no checker exists and err is tied 0.
// ----------------------------------------------------------------------------
module ring_counter_param #(
  parameter int WIDTH   = 4,
  parameter int JOHNSON = 0
) (
  input  logic                clk,
  input  logic                reset,
  ring_counter_param_if.slave bus
);

  localparam int               PERIOD  = (JOHNSON != 0) ? 2 * WIDTH : WIDTH;
  localparam int               PW      = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0]    POS_MAX = PW'(PERIOD - 1);
  localparam logic [PW:0]      POS_LIM = (PW + 1)'(PERIOD);
  localparam logic             FB_INV  = (JOHNSON != 0);
  localparam logic [WIDTH-1:0] RST_PAT = (JOHNSON != 0) ? '0 : WIDTH'(1);

  // Pattern implied by a position index; pos is the authoritative state.
  function automatic logic [WIDTH-1:0] f_pattern(input logic [PW-1:0] p);
    logic [WIDTH-1:0] v;
    int               pi;
    v  = '0;
    pi = 0;
    pi[PW-1:0] = p;
    for (int i = 0; i < WIDTH; i++) begin
      if (JOHNSON == 0)    v[i] = (pi == i);
      else if (pi <= WIDTH) v[i] = (i < pi);
      else                  v[i] = (i >= pi - WIDTH);
    end
    return v;
  endfunction

  logic [WIDTH-1:0] r_dout;
  logic [PW-1:0]    r_pos;
  logic             r_wrap;

  logic [WIDTH-1:0] w_dout_nxt;
  logic [PW-1:0]    w_pos_nxt;
  logic             w_wrap_nxt;
  logic             w_load_ok;
  logic             w_fix;

  assign w_load_ok = ({1'b0, bus.load_pos} < POS_LIM);

`ifdef RING_COUNTER_PARAM_SELF_CORRECT_EN
  logic r_err;

  assign w_fix = (r_dout != f_pattern(r_pos));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= w_fix;
  end

  assign bus.err = r_err;
`else
  assign w_fix   = 1'b0;
  assign bus.err = 1'b0;
`endif

  // Next state: repair, then load (an out-of-range load still blocks en),
  // then step, then hold. The feedback bit is inverted only for Johnson.
  always_comb begin
    w_dout_nxt = r_dout;
    w_pos_nxt  = r_pos;
    w_wrap_nxt = 1'b0;
    if (w_fix) begin
      w_dout_nxt = f_pattern(r_pos);
    end else if (bus.load) begin
      if (w_load_ok) begin
        w_dout_nxt = f_pattern(bus.load_pos);
        w_pos_nxt  = bus.load_pos;
      end
    end else if (bus.en) begin
      if (!bus.dir) begin
        w_dout_nxt = {r_dout[WIDTH-2:0], r_dout[WIDTH-1] ^ FB_INV};
        w_pos_nxt  = (r_pos == POS_MAX) ? '0 : r_pos + 1'b1;
        w_wrap_nxt = (r_pos == POS_MAX);
      end else begin
        w_dout_nxt = {r_dout[0] ^ FB_INV, r_dout[WIDTH-1:1]};
        w_pos_nxt  = (r_pos == '0) ? POS_MAX : r_pos - 1'b1;
        w_wrap_nxt = (r_pos == '0);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout <= RST_PAT;
      r_pos  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_dout <= w_dout_nxt;
      r_pos  <= w_pos_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign bus.dout = r_dout;
  assign bus.pos  = r_pos;
  assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_ring_counter_param.sv
// ----------------------------------------------------------------------------
// tb_ring_counter_param
// Directed bench for ring_counter_param: a 4-bit ring, a 4-bit Johnson and a
// 5-bit ring (non power-of-two period, so out-of-range loads exist).
// Expected values are hand-computed tables.
// ----------------------------------------------------------------------------
module tb_ring_counter_param;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ring_counter_param_if #(.WIDTH(4), .JOHNSON(0)) ifr ();
  ring_counter_param_if #(.WIDTH(4), .JOHNSON(1)) ifj ();
  ring_counter_param_if #(.WIDTH(5), .JOHNSON(0)) if5 ();

  ring_counter_param #(.WIDTH(4), .JOHNSON(0)) dut_r  (.clk(clk), .reset(reset), .bus(ifr));
  ring_counter_param #(.WIDTH(4), .JOHNSON(1)) dut_j  (.clk(clk), .reset(reset), .bus(ifj));
  ring_counter_param #(.WIDTH(5), .JOHNSON(0)) dut_r5 (.clk(clk), .reset(reset), .bus(if5));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifr.en = 1'b0; ifr.dir = 1'b0; ifr.load = 1'b0; ifr.load_pos = 2'd0;
    ifj.en = 1'b0; ifj.dir = 1'b0; ifj.load = 1'b0; ifj.load_pos = 3'd0;
    if5.en = 1'b0; if5.dir = 1'b0; if5.load = 1'b0; if5.load_pos = 3'd0;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1'b1;
    #2;
    n_checks++; if (ifr.dout !== 4'b0001) begin n_fail++; $display("FAIL reset_ring_dout: got %b expected 0001", ifr.dout); end
    n_checks++; if (ifr.pos !== 2'd0) begin n_fail++; $display("FAIL reset_ring_pos: got %0d expected 0", ifr.pos); end
    n_checks++; if (ifr.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_ring_wrap: got %b expected 0", ifr.wrap); end
    n_checks++; if (ifr.err !== 1'b0) begin n_fail++; $display("FAIL reset_ring_err: got %b expected 0", ifr.err); end
    n_checks++; if (ifj.dout !== 4'b0000) begin n_fail++; $display("FAIL reset_john_dout: got %b expected 0000", ifj.dout); end
    n_checks++; if (ifj.pos !== 3'd0) begin n_fail++; $display("FAIL reset_john_pos: got %0d expected 0", ifj.pos); end
    n_checks++; if (if5.dout !== 5'b00001) begin n_fail++; $display("FAIL reset_r5_dout: got %b expected 00001", if5.dout); end
    // en while reset is held must not move anything
    ifr.en = 1'b1;
    step();
    n_checks++; if (ifr.dout !== 4'b0001) begin n_fail++; $display("FAIL reset_hold_dout: got %b expected 0001", ifr.dout); end
    ifr.en = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_ring_up();
    logic [3:0] ed [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [1:0] ep [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       ew [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    ifr.en = 1'b1; ifr.dir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (ifr.dout !== ed[i]) begin n_fail++; $display("FAIL ring_up_dout[%0d]: got %b expected %b", i, ifr.dout, ed[i]); end
      n_checks++; if (ifr.pos !== ep[i]) begin n_fail++; $display("FAIL ring_up_pos[%0d]: got %0d expected %0d", i, ifr.pos, ep[i]); end
      n_checks++; if (ifr.wrap !== ew[i]) begin n_fail++; $display("FAIL ring_up_wrap[%0d]: got %b expected %b", i, ifr.wrap, ew[i]); end
    end
    ifr.en = 1'b0;
  endtask

  task automatic test_johnson_up();
    logic [3:0] ed [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                           4'b1100, 4'b1000, 4'b0000, 4'b0001};
    logic [2:0] ep [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    logic       ew [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    ifj.en = 1'b1; ifj.dir = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      n_checks++; if (ifj.dout !== ed[i]) begin n_fail++; $display("FAIL john_up_dout[%0d]: got %b expected %b", i, ifj.dout, ed[i]); end
      n_checks++; if (ifj.pos !== ep[i]) begin n_fail++; $display("FAIL john_up_pos[%0d]: got %0d expected %0d", i, ifj.pos, ep[i]); end
      n_checks++; if (ifj.wrap !== ew[i]) begin n_fail++; $display("FAIL john_up_wrap[%0d]: got %b expected %b", i, ifj.wrap, ew[i]); end
    end
    ifj.en = 1'b0;
  endtask

  task automatic test_ring_down();
    logic       dr [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] ed [4] = '{4'b1000, 4'b0100, 4'b1000, 4'b0100};
    logic [1:0] ep [4] = '{2'd3, 2'd2, 2'd3, 2'd2};
    logic       ew [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    ifr.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifr.dir = dr[i];
      step();
      n_checks++; if (ifr.dout !== ed[i]) begin n_fail++; $display("FAIL ring_dn_dout[%0d]: got %b expected %b", i, ifr.dout, ed[i]); end
      n_checks++; if (ifr.pos !== ep[i]) begin n_fail++; $display("FAIL ring_dn_pos[%0d]: got %0d expected %0d", i, ifr.pos, ep[i]); end
      n_checks++; if (ifr.wrap !== ew[i]) begin n_fail++; $display("FAIL ring_dn_wrap[%0d]: got %b expected %b", i, ifr.wrap, ew[i]); end
    end
    ifr.en = 1'b0; ifr.dir = 1'b0;
  endtask

  task automatic test_load();
    // Johnson: load 5, load 0 (from 5, no wrap), then step down across 0
    logic       jl [3] = '{1'b1, 1'b1, 1'b0};
    logic [2:0] jp [3] = '{3'd5, 3'd0, 3'd0};
    logic       jr [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0] jd [3] = '{4'b1110, 4'b0000, 4'b1000};
    logic [2:0] jq [3] = '{3'd5, 3'd0, 3'd7};
    logic       jw [3] = '{1'b0, 1'b0, 1'b1};
    // 5-bit ring: load 4, out-of-range 6 and 5 with en=1, then step up
    logic       fl [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] fp [4] = '{3'd4, 3'd6, 3'd5, 3'd0};
    logic [4:0] fd [4] = '{5'b10000, 5'b10000, 5'b10000, 5'b00001};
    logic [2:0] fq [4] = '{3'd4, 3'd4, 3'd4, 3'd0};
    logic       fw [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    ifj.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifj.load = jl[i]; ifj.load_pos = jp[i]; ifj.dir = jr[i];
      step();
      n_checks++; if (ifj.dout !== jd[i]) begin n_fail++; $display("FAIL john_load_dout[%0d]: got %b expected %b", i, ifj.dout, jd[i]); end
      n_checks++; if (ifj.pos !== jq[i]) begin n_fail++; $display("FAIL john_load_pos[%0d]: got %0d expected %0d", i, ifj.pos, jq[i]); end
      n_checks++; if (ifj.wrap !== jw[i]) begin n_fail++; $display("FAIL john_load_wrap[%0d]: got %b expected %b", i, ifj.wrap, jw[i]); end
    end
    idle_all();
    if5.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if5.load = fl[i]; if5.load_pos = fp[i];
      step();
      n_checks++; if (if5.dout !== fd[i]) begin n_fail++; $display("FAIL r5_load_dout[%0d]: got %b expected %b", i, if5.dout, fd[i]); end
      n_checks++; if (if5.pos !== fq[i]) begin n_fail++; $display("FAIL r5_load_pos[%0d]: got %0d expected %0d", i, if5.pos, fq[i]); end
      n_checks++; if (if5.wrap !== fw[i]) begin n_fail++; $display("FAIL r5_load_wrap[%0d]: got %b expected %b", i, if5.wrap, fw[i]); end
    end
    idle_all();
  endtask

  task automatic test_async_reset();
    do_reset();
    ifr.en = 1'b1; ifr.dir = 1'b0;
    step();
    step();
    ifr.en = 1'b0;
    step();
    n_checks++; if (ifr.dout !== 4'b0100) begin n_fail++; $display("FAIL arst_pre_dout: got %b expected 0100", ifr.dout); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (ifr.dout !== 4'b0001) begin n_fail++; $display("FAIL arst_dout: got %b expected 0001", ifr.dout); end
    n_checks++; if (ifr.pos !== 2'd0) begin n_fail++; $display("FAIL arst_pos: got %0d expected 0", ifr.pos); end
    #1 reset = 1'b0;
    ifr.en = 1'b1;
    step();
    n_checks++; if (ifr.dout !== 4'b0010) begin n_fail++; $display("FAIL arst_next_dout: got %b expected 0010", ifr.dout); end
    // step down twice to raise wrap, then clear it asynchronously
    ifr.dir = 1'b1;
    step();
    step();
    n_checks++; if (ifr.wrap !== 1'b1) begin n_fail++; $display("FAIL arst_wrap_pre: got %b expected 1", ifr.wrap); end
    ifr.en = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (ifr.wrap !== 1'b0) begin n_fail++; $display("FAIL arst_wrap_clr: got %b expected 0", ifr.wrap); end
    n_checks++; if (ifr.dout !== 4'b0001) begin n_fail++; $display("FAIL arst_wrap_dout: got %b expected 0001", ifr.dout); end
    #1 reset = 1'b0;
    idle_all();
  endtask

  task automatic test_self_correct();
    logic [3:0] d1, d2;
    logic [1:0] p1, p2;
    logic       e1;
`ifdef RING_COUNTER_PARAM_SELF_CORRECT_EN
    d1 = 4'b0010; p1 = 2'd1; e1 = 1'b1; d2 = 4'b0010; p2 = 2'd1;
`else
    d1 = 4'b1100; p1 = 2'd2; e1 = 1'b0; d2 = 4'b1100; p2 = 2'd2;
`endif
    do_reset();
    ifr.en = 1'b1; ifr.dir = 1'b0;
    step();
    n_checks++; if (ifr.dout !== 4'b0010) begin n_fail++; $display("FAIL sc_pre_dout: got %b expected 0010", ifr.dout); end
    // corrupt the register between edges; en stays high into the repair cycle
    #2 force dut_r.r_dout = 4'b0110;
    #1 release dut_r.r_dout;
    step();
    n_checks++; if (ifr.dout !== d1) begin n_fail++; $display("FAIL sc_fix_dout: got %b expected %b", ifr.dout, d1); end
    n_checks++; if (ifr.pos !== p1) begin n_fail++; $display("FAIL sc_fix_pos: got %0d expected %0d", ifr.pos, p1); end
    n_checks++; if (ifr.err !== e1) begin n_fail++; $display("FAIL sc_fix_err: got %b expected %b", ifr.err, e1); end
    ifr.en = 1'b0;
    step();
    n_checks++; if (ifr.dout !== d2) begin n_fail++; $display("FAIL sc_after_dout: got %b expected %b", ifr.dout, d2); end
    n_checks++; if (ifr.pos !== p2) begin n_fail++; $display("FAIL sc_after_pos: got %0d expected %0d", ifr.pos, p2); end
    n_checks++; if (ifr.err !== 1'b0) begin n_fail++; $display("FAIL sc_after_err: got %b expected 0", ifr.err); end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_ring_up();
    test_johnson_up();
    test_ring_down();
    test_load();
    test_async_reset();
    test_self_correct();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
